// File: rtl/bubbledrive8_flash_arbiter.sv
// Flash bus arbiter: shares one SPI/QSPI flash between the emulator core and the
// USB/MPSSE path. Fixed emulator priority, chip-select deselect guard between
// owners, and a yield request to a USB owner that has held the bus too long.
module bubbledrive8_flash_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned USB_MAXHOLD  = 24000,
  parameter int unsigned CNTW         = 16
) (
  input  logic MCLK,
  input  logic MRST,
  input  logic nEMUEN,
  input  logic nUSBEN,
  input  logic nEMUREQ,
  input  logic nUSBREQ,
  output logic nEMUGNT,
  output logic nUSBGNT,
  output logic nUSBYIELD,
  input  logic EMU_nCS,
  input  logic EMU_CLK,
  input  logic EMU_MOSI,
  input  logic EMU_MOSIOE,
  input  logic USB_nCS,
  input  logic USB_CLK,
  input  logic USB_MOSI,
  input  logic USB_MOSIOE,
  output logic nROMCS,
  output logic ROMCLK,
  output logic ROMIO0_O,
  output logic ROMIO0_OE,
  output logic nBUSY
);

  typedef enum logic [1:0] {StIdle, StEmuOwn, StUsbOwn, StGuard} state_e;

  localparam logic [CNTW-1:0] GuardLast = CNTW'(GUARD_CYCLES - 1);
  localparam logic [CNTW-1:0] HoldLimit = CNTW'(USB_MAXHOLD);

  state_e          r_state, w_state_d;
  logic [CNTW-1:0] r_guard_cnt, w_guard_cnt_d;
  logic [CNTW-1:0] r_hold_cnt, w_hold_cnt_d;
  logic            r_nemugnt, w_nemugnt_d;
  logic            r_nusbgnt, w_nusbgnt_d;
  logic            r_nusbyield, w_nusbyield_d;
  logic            r_nbusy, w_nbusy_d;
  logic            w_ereq, w_ureq, w_yield;

  assign w_ereq = ~nEMUREQ & ~nEMUEN;
  assign w_ureq = ~nUSBREQ & ~nUSBEN;

  // Next-state, counters and registered handshake outputs.
  always_comb begin
    w_state_d     = r_state;
    w_guard_cnt_d = '0;
    w_hold_cnt_d  = '0;
    w_yield       = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Emulator wins a tie; it is the timing-critical master.
        if (w_ereq) begin
          w_state_d = StEmuOwn;
        end else if (w_ureq) begin
          w_state_d = StUsbOwn;
        end
      end
      StEmuOwn: begin
        if (!w_ereq) w_state_d = StGuard;
      end
      StUsbOwn: begin
        if (!w_ureq) begin
          w_state_d = StGuard;
        end else begin
          w_hold_cnt_d = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
          // Only a request to yield; the USB owner is never revoked.
          w_yield      = (r_hold_cnt >= HoldLimit) && w_ereq;
        end
      end
      StGuard: begin
        if (r_guard_cnt == GuardLast) begin
          w_state_d = StIdle;
        end else begin
          w_guard_cnt_d = r_guard_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_nemugnt_d   = (w_state_d != StEmuOwn);
    w_nusbgnt_d   = (w_state_d != StUsbOwn);
    w_nbusy_d     = (w_state_d == StIdle);
    w_nusbyield_d = ~w_yield;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge MCLK) begin
    if (MRST) begin
      r_state     <= StIdle;
      r_guard_cnt <= '0;
      r_hold_cnt  <= '0;
      r_nemugnt   <= 1'b1;
      r_nusbgnt   <= 1'b1;
      r_nusbyield <= 1'b1;
      r_nbusy     <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_guard_cnt <= w_guard_cnt_d;
      r_hold_cnt  <= w_hold_cnt_d;
      r_nemugnt   <= w_nemugnt_d;
      r_nusbgnt   <= w_nusbgnt_d;
      r_nusbyield <= w_nusbyield_d;
      r_nbusy     <= w_nbusy_d;
    end
  end

  assign nEMUGNT   = r_nemugnt;
  assign nUSBGNT   = r_nusbgnt;
  assign nUSBYIELD = r_nusbyield;
  assign nBUSY     = r_nbusy;

  // Pin mux from the registered owner; parked (deselected, not driving) otherwise.
  always_comb begin
    nROMCS    = 1'b1;
    ROMCLK    = 1'b0;
    ROMIO0_O  = 1'b0;
    ROMIO0_OE = 1'b0;
    unique case (r_state)
      StEmuOwn: begin
        nROMCS    = EMU_nCS;
        ROMCLK    = EMU_CLK;
        ROMIO0_O  = EMU_MOSI;
        ROMIO0_OE = EMU_MOSIOE;
      end
      StUsbOwn: begin
        nROMCS    = USB_nCS;
        ROMCLK    = USB_CLK;
        ROMIO0_O  = USB_MOSI;
        ROMIO0_OE = USB_MOSIOE;
      end
      StIdle, StGuard: begin
        nROMCS    = 1'b1;
        ROMCLK    = 1'b0;
        ROMIO0_O  = 1'b0;
        ROMIO0_OE = 1'b0;
      end
      default: begin
        nROMCS    = 1'b1;
        ROMCLK    = 1'b0;
        ROMIO0_O  = 1'b0;
        ROMIO0_OE = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bubbledrive8_flash_arbiter.sv
// Directed bench for the flash arbiter: grant timing, guard gap, yield, forced
// release, mid-transfer reset and disabled requester.
module tb_bubbledrive8_flash_arbiter;

  logic MCLK = 1'b0;
  logic MRST;
  logic nEMUEN, nUSBEN, nEMUREQ, nUSBREQ;
  logic nEMUGNT, nUSBGNT, nUSBYIELD;
  logic EMU_nCS, EMU_CLK, EMU_MOSI, EMU_MOSIOE;
  logic USB_nCS, USB_CLK, USB_MOSI, USB_MOSIOE;
  logic nROMCS, ROMCLK, ROMIO0_O, ROMIO0_OE, nBUSY;

  int n_checks = 0;
  int n_fail   = 0;

  bubbledrive8_flash_arbiter dut (
    .MCLK       (MCLK),
    .MRST       (MRST),
    .nEMUEN     (nEMUEN),
    .nUSBEN     (nUSBEN),
    .nEMUREQ    (nEMUREQ),
    .nUSBREQ    (nUSBREQ),
    .nEMUGNT    (nEMUGNT),
    .nUSBGNT    (nUSBGNT),
    .nUSBYIELD  (nUSBYIELD),
    .EMU_nCS    (EMU_nCS),
    .EMU_CLK    (EMU_CLK),
    .EMU_MOSI   (EMU_MOSI),
    .EMU_MOSIOE (EMU_MOSIOE),
    .USB_nCS    (USB_nCS),
    .USB_CLK    (USB_CLK),
    .USB_MOSI   (USB_MOSI),
    .USB_MOSIOE (USB_MOSIOE),
    .nROMCS     (nROMCS),
    .ROMCLK     (ROMCLK),
    .ROMIO0_O   (ROMIO0_O),
    .ROMIO0_OE  (ROMIO0_OE),
    .nBUSY      (nBUSY)
  );

  always #5 MCLK = ~MCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic check_pins(input string tag, input logic cs, input logic ck, input logic mo,
                            input logic oe);
    check_eq({tag, "_cs"}, nROMCS, cs);
    check_eq({tag, "_clk"}, ROMCLK, ck);
    check_eq({tag, "_mosi"}, ROMIO0_O, mo);
    check_eq({tag, "_oe"}, ROMIO0_OE, oe);
  endtask

  initial begin
    int n;
    MRST    = 1'b1;
    nEMUEN  = 1'b0;
    nUSBEN  = 1'b0;
    nEMUREQ = 1'b1;
    nUSBREQ = 1'b1;
    EMU_nCS = 1'b0; EMU_CLK = 1'b1; EMU_MOSI = 1'b1; EMU_MOSIOE = 1'b1;
    USB_nCS = 1'b1; USB_CLK = 1'b0; USB_MOSI = 1'b0; USB_MOSIOE = 0;
    repeat (3) tick();
    check_eq("rst_emugnt", nEMUGNT, 1'b1);
    check_eq("rst_usbgnt", nUSBGNT, 1'b1);
    check_eq("rst_yield", nUSBYIELD, 1'b1);
    check_eq("rst_busy", nBUSY, 1'b1);
    check_pins("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    MRST = 1'b0;
    repeat (5) tick();

    // Emulator alone.
    nEMUREQ = 1'b0;
    check_eq("emu_pre_gnt", nEMUGNT, 1'b1);
    tick();
    check_eq("emu_gnt", nEMUGNT, 1'b0);
    check_eq("emu_busy", nBUSY, 1'b0);
    check_eq("emu_usbgnt", nUSBGNT, 1'b1);
    check_pins("emu_mux", 1'b0, 1'b1, 1'b1, 1'b1);
    EMU_nCS = 1'b1; EMU_CLK = 1'b0; #1;
    check_eq("emu_cs_follow", nROMCS, 1'b1);
    check_eq("emu_clk_follow", ROMCLK, 1'b0);
    EMU_nCS = 1'b0;
    repeat (10) tick();
    nEMUREQ = 1'b1;
    tick();
    check_eq("emu_rel_gnt", nEMUGNT, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("guard_cs", nROMCS, 1'b1);
      check_eq("guard_busy", nBUSY, 1'b0);
      tick();
    end
    check_eq("guard_exit_busy", nBUSY, 1'b1);

    // Simultaneous requests: emulator first, USB after the guard gap.
    USB_nCS = 1'b0; USB_CLK = 1'b1; USB_MOSI = 1'b1; USB_MOSIOE = 1'b0;
    nEMUREQ = 1'b0;
    nUSBREQ = 1'b0;
    tick();
    check_eq("sim_emugnt", nEMUGNT, 1'b0);
    check_eq("sim_usbgnt", nUSBGNT, 1'b1);
    repeat (10) tick();
    check_eq("sim_usb_wait", nUSBGNT, 1'b1);
    nEMUREQ = 1'b1;
    n = 0;
    while (nUSBGNT !== 1'b0 && n < 20) begin
      tick();
      n++;
      if (nUSBGNT === 1'b1) check_eq("sim_no_overlap", nEMUGNT | nROMCS, 1'b1);
    end
    check_eq("sim_usb_gap", n, 6);
    check_eq("sim_emugnt_off", nEMUGNT, 1'b1);
    check_pins("usb_mux", 1'b0, 1'b1, 1'b1, 1'b0);

    // Yield: not before the hold limit, then asserted one cycle after the request.
    nEMUREQ = 1'b0;
    tick();
    tick();
    check_eq("yield_early", nUSBYIELD, 1'b1);
    nEMUREQ = 1'b1;
    repeat (30000) tick();
    check_eq("yield_no_req", nUSBYIELD, 1'b1);
    nEMUREQ = 1'b0;
    tick();
    check_eq("yield_on", nUSBYIELD, 1'b0);
    check_eq("yield_keep_gnt", nUSBGNT, 1'b0);
    check_eq("yield_no_emugnt", nEMUGNT, 1'b1);
    repeat (20) tick();
    check_eq("yield_hold_gnt", nUSBGNT, 1'b0);
    check_eq("yield_still", nUSBYIELD, 1'b0);
    nUSBREQ = 1'b1;
    tick();
    check_eq("yield_rel_gnt", nUSBGNT, 1'b1);
    check_eq("yield_off", nUSBYIELD, 1'b1);
    n = 1;
    while (nEMUGNT !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("yield_emu_gap", n, 6);
    nEMUREQ = 1'b1;
    repeat (5) tick();
    check_eq("yield_idle", nBUSY, 1'b1);

    // Forced USB release via enable.
    USB_MOSIOE = 1'b1;
    nUSBREQ = 1'b0;
    tick();
    check_eq("frc_gnt", nUSBGNT, 1'b0);
    check_eq("frc_oe_on", ROMIO0_OE, 1'b1);
    nUSBEN = 1'b1;
    tick();
    check_eq("frc_gnt_off", nUSBGNT, 1'b1);
    check_pins("frc_park", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("frc_guard_busy", nBUSY, 1'b0);
    nUSBEN = 1'b0;
    nUSBREQ = 1'b1;
    repeat (3) tick();
    check_eq("frc_guard_end", nBUSY, 1'b0);
    tick();
    check_eq("frc_idle", nBUSY, 1'b1);

    // Mid-transfer reset: pins parked, re-grant without guard.
    nEMUREQ = 1'b0;
    tick();
    check_eq("mrst_gnt", nEMUGNT, 1'b0);
    MRST = 1'b1;
    tick();
    check_eq("mrst_emugnt", nEMUGNT, 1'b1);
    check_eq("mrst_busy", nBUSY, 1'b1);
    check_eq("mrst_yield", nUSBYIELD, 1'b1);
    check_pins("mrst", 1'b1, 1'b0, 1'b0, 1'b0);
    MRST = 1'b0;
    tick();
    check_eq("mrst_regnt", nEMUGNT, 1'b0);
    nEMUREQ = 1'b1;
    repeat (5) tick();
    check_eq("mrst_idle", nBUSY, 1'b1);

    // Disabled requester is ignored.
    nEMUEN  = 1'b1;
    nEMUREQ = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("dis_gnt", nEMUGNT, 1'b1);
      check_eq("dis_busy", nBUSY, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bubbledrive8_flash_arbiter.md
Name: bubbledrive8_flash_arbiter

Overview:
- Shares the single W25Q32 SPI/QSPI flash between two masters: the emulator core (bubble page fetch, timing-critical) and the USB/MPSSE path (flash programming/readback).
- Grants ownership with an active-low request/grant handshake and muxes the flash pins to the owner.
- Enforces a chip-select deselect guard time between owners, and asks a long-holding USB owner to yield when the emulator is waiting.
- Sits between the emulator/USB cores and the flash pins in the top level.

Parameters:
- GUARD_CYCLES, 4: MCLK cycles nROMCS is held high after any release before the next grant (≥50 ns tSHSL at 48 MHz).
- USB_MAXHOLD, 24000: USB hold cycles (500 µs) after which nUSBYIELD asserts if the emulator is requesting.
- CNTW, 16: width of the guard/hold counters; must hold both USB_MAXHOLD and GUARD_CYCLES.

Ports:
- MCLK  in  1  48 MHz clock; the only clock.
- MRST  in  1  reset, synchronous, active-high.
- nEMUEN  in  1  emulator requester enable, active-low.
- nUSBEN  in  1  USB/MPSSE requester enable, active-low.
- nEMUREQ  in  1  emulator bus request, active-low.
- nUSBREQ  in  1  USB bus request, active-low.
- nEMUGNT  out  1  emulator grant, active-low.
- nUSBGNT  out  1  USB grant, active-low.
- nUSBYIELD  out  1  asks the USB owner to finish and release, active-low.
- EMU_nCS, EMU_CLK, EMU_MOSI, EMU_MOSIOE  in  1 each  emulator flash pin drive.
- USB_nCS, USB_CLK, USB_MOSI, USB_MOSIOE  in  1 each  USB flash pin drive.
- nROMCS  out  1  flash chip select.
- ROMCLK  out  1  flash clock.
- ROMIO0_O  out  1  IO0 output value.
- ROMIO0_OE  out  1  IO0 output enable; the top level builds the tristate.
- nBUSY  out  1  low while any owner holds the bus or guard is running.

Behaviour:
- Reset is synchronous and active-high on MRST, clock MCLK. With MRST high, on every edge the block goes to IDLE and clears both counters.
- Reset output values: nEMUGNT=1, nUSBGNT=1, nUSBYIELD=1, nROMCS=1, ROMCLK=0, ROMIO0_O=0, ROMIO0_OE=0, nBUSY=1.
- Reset asserted mid-transfer drops the grant and parks the pins on the next edge; no guard is applied because nROMCS is already high.
- Effective requests:
  - ereq = ~nEMUREQ & ~nEMUEN.
  - ureq = ~nUSBREQ & ~nUSBEN.
- States: IDLE, EMU_OWN, USB_OWN, GUARD. State, grants, yield and nBUSY are registered.
- IDLE:
  - ereq → EMU_OWN.
  - else ureq → USB_OWN.
  - ereq and ureq in the same cycle → EMU_OWN (fixed emulator priority).
  - Grant is visible one cycle after the request is sampled.
- EMU_OWN: stays while ereq. On ~ereq (release or nEMUEN high) → GUARD, and nEMUGNT deasserts the same edge.
- USB_OWN:
  - The hold counter increments every cycle, saturating at its maximum.
  - nUSBYIELD=0 while hold ≥ USB_MAXHOLD and ereq.
  - The USB owner is never forcibly revoked by an emulator request.
  - On ~ureq → GUARD, which includes the case where nUSBEN goes high (forced release).
  - The hold counter clears on leaving USB_OWN.
- GUARD:
  - The counter counts 0..GUARD_CYCLES-1, then the block goes to IDLE.
  - Requests arriving during GUARD are not granted until GUARD exits.
  - Priority is evaluated in IDLE, so the minimum gap from release to next grant is GUARD_CYCLES+2 cycles.
- A release and the other master's request in the same cycle → GUARD first; no back-to-back handover.
- Pin mux is combinational from the registered owner state; it adds no latency on the pin path.
  - EMU_OWN: pins = EMU_*.
  - USB_OWN: pins = USB_*.
  - IDLE/GUARD: pins forced to the reset values.
- MISO/IO1-3 are not muxed; both masters read the shared inputs directly.
- nBUSY=0 in EMU_OWN, USB_OWN and GUARD.
- Exactly one grant is low at most, at all times; a grant is never low in IDLE or GUARD.

Test Plan:
- Emulator alone:
  - Stimulus: after reset, nEMUREQ=0 at cycle 10.
  - Required: nEMUGNT=0 at cycle 11; nROMCS follows EMU_nCS.
  - Stimulus: release at cycle 50.
  - Required: nEMUGNT=1 at 51; nROMCS=1 for 4 cycles; IDLE at 55.
- Simultaneous requests:
  - Stimulus: nEMUREQ and nUSBREQ both fall at cycle 10.
  - Required: nEMUGNT=0 at 11; nUSBGNT stays 1.
  - Stimulus: emulator releases at 40.
  - Required: nUSBGNT=0 at 46, i.e. GUARD_CYCLES+2 cycles after release.
- USB yield:
  - Stimulus: USB owns; nEMUREQ=0 after 30000 hold cycles.
  - Required: nUSBYIELD=0 the next cycle; the USB grant is retained until nUSBREQ=1; then guard, then nEMUGNT=0.
- Forced USB release:
  - Stimulus: USB owns; nUSBEN=1 at cycle N with nUSBREQ still 0.
  - Required: nUSBGNT=1 at N+1; pins parked (nROMCS=1, ROMIO0_OE=0); guard runs.
- Mid-transfer reset:
  - Stimulus: MRST=1 for 1 cycle during EMU_OWN.
  - Required: all outputs at reset values next edge; on MRST=0 with nEMUREQ=0, re-grant 1 cycle later with no guard.
- Disabled requester:
  - Stimulus: nEMUEN=1 and nEMUREQ=0 for 100 cycles.
  - Required: no grant; nBUSY=1 throughout.
